// File: rtl/serial_link_pkg.sv
// Shared serial-link definitions: FSM state encodings and counter sizing.
// Used by both the transmit (byte_serializer) and receive sides.
package serial_link_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2,
    ST_GAP    = 2'd3
  } state_t;

  localparam int GAP_MAX = 15;

  // Bits needed to hold the values 0..n.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/serial_bit_counter.sv
// Loadable down-counter with terminal-count flag; sticks at zero.
// Serves as both the bit counter and the inter-frame gap counter.
module serial_bit_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_tc
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_tc = (r_count == '0);

endmodule

// File: rtl/byte_serializer.sv
// Parallel-to-serial transmitter: one WIDTH-bit word per handshake, one bit per clk.
// Optional even-parity trailer cycle when BYTE_SERIALIZER_PARITY_EN is defined.
//
// Handshake: a word is accepted on a rising edge where in_valid && in_ready;
// in_ready never depends on in_valid, and the producer holds in_data/in_valid
// steady until accepted.
module byte_serializer
  import serial_link_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int GAP       = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             data,
  output logic             frame,
  output logic             done,
  output state_t           o_dbg_state
);

  localparam int BW = cnt_width(WIDTH);
  localparam int GW = cnt_width(GAP_MAX);
  localparam logic [BW-1:0] BIT_LOAD = BW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'((GAP > 0) ? GAP - 1 : 0);
  localparam bit HAS_GAP = (GAP > 0);

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_buf, w_buf_nxt;
  logic             r_data, w_data_nxt;
  logic             w_bit_load, w_bit_dec, w_bit_tc;
  logic             w_gap_load, w_gap_dec, w_gap_tc;
  logic             w_accept, w_last_bit, w_final;

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  // Moves the next bit to be sent into the first_bit() position.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  serial_bit_counter #(.W(BW)) u_bit_cnt (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_bit_load),
    .i_load_val (BIT_LOAD),
    .i_dec      (w_bit_dec),
    .o_tc       (w_bit_tc)
  );

  serial_bit_counter #(.W(GW)) u_gap_cnt (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_gap_load),
    .i_load_val (GAP_LOAD),
    .i_dec      (w_gap_dec),
    .o_tc       (w_gap_tc)
  );

  assign w_last_bit = (r_state == ST_SHIFT) && w_bit_tc;
`ifdef BYTE_SERIALIZER_PARITY_EN
  logic r_par;
  assign w_final = (r_state == ST_PARITY);
`else
  assign w_final = w_last_bit;
`endif

  // Zero-bubble window: with no gap the final frame cycle may accept the next word.
  assign in_ready = reset && ((r_state == ST_IDLE) || (!HAS_GAP && w_final));
  assign w_accept = in_valid && in_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_data_nxt  = 1'b0;
    w_buf_nxt   = r_buf;
    w_bit_load  = 1'b0;
    w_bit_dec   = 1'b0;
    w_gap_load  = 1'b0;
    w_gap_dec   = 1'b0;
    unique case (r_state)
      ST_IDLE: ;
      ST_SHIFT: begin
        if (!w_bit_tc) begin
          w_data_nxt = first_bit(r_buf);
          w_buf_nxt  = advance(r_buf);
          w_bit_dec  = 1'b1;
        end else begin
`ifdef BYTE_SERIALIZER_PARITY_EN
          w_state_nxt = ST_PARITY;
          w_data_nxt  = r_par;
`else
          w_state_nxt = HAS_GAP ? ST_GAP : ST_IDLE;
          w_gap_load  = HAS_GAP;
`endif
        end
      end
      ST_PARITY: begin
        w_state_nxt = HAS_GAP ? ST_GAP : ST_IDLE;
        w_gap_load  = HAS_GAP;
      end
      ST_GAP: begin
        w_gap_dec = 1'b1;
        if (w_gap_tc) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_accept) begin
      w_state_nxt = ST_SHIFT;
      w_data_nxt  = first_bit(in_data);
      w_buf_nxt   = advance(in_data);
      w_bit_load  = 1'b1;
      w_gap_load  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_data  <= 1'b0;
      r_buf   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_data  <= w_data_nxt;
      r_buf   <= w_buf_nxt;
    end
  end

`ifdef BYTE_SERIALIZER_PARITY_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_par <= 1'b0;
    end else if (w_accept) begin
      r_par <= ^in_data;
    end
  end
`endif

  assign data        = r_data;
  assign frame       = (r_state == ST_SHIFT) || (r_state == ST_PARITY);
  assign done        = w_final;
  assign o_dbg_state = r_state;

endmodule
